// File: rtl/wiredleg_div_ctrl.sv
// Divide/remainder request sequencer for an external fixed-latency divider.
// Optional macro WIREDLEG_DIV_FASTPATH_EN resolves B==0 and signed overflow without the divider.
module wiredleg_div_ctrl #(
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_data,
  output logic [TAG_W-1:0] resp_tag,
  output logic             busy,
  output logic             div_start,
  output logic             div_sign,
  output logic [31:0]      div_a,
  output logic [31:0]      div_b,
  input  logic             div_busy,
  input  logic [31:0]      div_quo,
  input  logic [31:0]      div_rem
);

  typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

  state_t      state;
  logic        sel_rem;
  logic        fp_hit;
  logic [31:0] fp_data;

`ifdef WIREDLEG_DIV_FASTPATH_EN
  logic fp_zero;
  logic fp_ovf;
  assign fp_zero = (req_b == '0);
  assign fp_ovf  = !req_op[1] && (req_a == 32'h8000_0000) && (req_b == '1);
  assign fp_hit  = fp_zero || fp_ovf;
  // Divide-by-zero: quotient all ones, remainder is the dividend; overflow: quotient MIN, remainder 0.
  assign fp_data = fp_zero ? (req_op[0] ? req_a : '1)
                           : (req_op[0] ? '0 : 32'h8000_0000);
`else
  assign fp_hit  = 1'b0;
  assign fp_data = '0;
`endif

  assign req_ready  = (state == IDLE) && !flush;
  assign busy       = (state != IDLE);
  assign div_start  = (state == START);
  // Masking keeps a response from transferring in the same cycle it is being flushed.
  assign resp_valid = (state == DONE) && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      div_sign  <= 1'b0;
      sel_rem   <= 1'b0;
      div_a     <= '0;
      div_b     <= '0;
      resp_tag  <= '0;
      resp_data <= '0;
    end else if (flush) begin
      state <= IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            div_sign <= !req_op[1];
            sel_rem  <= req_op[0];
            div_a    <= req_a;
            div_b    <= req_b;
            resp_tag <= req_tag;
            if (fp_hit) begin
              resp_data <= fp_data;
              state     <= DONE;
            end else begin
              state <= START;
            end
          end
        end
        START: state <= WAIT;
        WAIT: begin
          if (!div_busy) begin
            resp_data <= sel_rem ? div_rem : div_quo;
            state     <= DONE;
          end
        end
        DONE: begin
          if (resp_ready) state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wiredleg_div_ctrl.sv
// Self-checking bench for wiredleg_div_ctrl: reference model plus directed vectors.
// Build with +define+WIREDLEG_DIV_FASTPATH_EN to exercise the fastpath variant.
module tb_wiredleg_div_ctrl;
  localparam int TAG_W = 5;
`ifdef WIREDLEG_DIV_FASTPATH_EN
  localparam int FP_LAT = 0;
`else
  localparam int FP_LAT = 34;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             flush = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [1:0]       req_op = '0;
  logic [31:0]      req_a = '0;
  logic [31:0]      req_b = '0;
  logic [TAG_W-1:0] req_tag = '0;
  logic             resp_valid;
  logic             resp_ready = 1'b1;
  logic [31:0]      resp_data;
  logic [TAG_W-1:0] resp_tag;
  logic             busy;
  logic             div_start;
  logic             div_sign;
  logic [31:0]      div_a;
  logic [31:0]      div_b;
  logic             div_busy = 1'b0;
  logic [31:0]      div_quo = '0;
  logic [31:0]      div_rem = '0;

  int total = 0;
  int bad = 0;

  wiredleg_div_ctrl #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_tag(resp_tag), .busy(busy),
    .div_start(div_start), .div_sign(div_sign), .div_a(div_a), .div_b(div_b),
    .div_busy(div_busy), .div_quo(div_quo), .div_rem(div_rem)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Stand-in divider: 32 busy cycles after start, sign handled by magnitudes.
  function automatic logic [63:0] stub_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ma, mb, q, r;
    if (b == 32'd0) return {32'hFFFF_FFFF, a};
    if (!sgn) return {a / b, a % b};
    ma = a[31] ? (32'd0 - a) : a;
    mb = b[31] ? (32'd0 - b) : b;
    q = ma / mb;
    r = ma % mb;
    if (a[31] ^ b[31]) q = 32'd0 - q;
    if (a[31]) r = 32'd0 - r;
    return {q, r};
  endfunction

  logic [31:0] st_q = '0;
  logic [31:0] st_r = '0;
  int          st_cnt = 0;
  always @(posedge clk) begin
    if (div_start) begin
      st_cnt <= 32;
      div_busy <= 1'b1;
      {st_q, st_r} <= stub_div(div_sign, div_a, div_b);
      div_quo <= 32'hDEAD_BEEF;
      div_rem <= 32'hDEAD_BEEF;
    end else if (st_cnt != 0) begin
      st_cnt <= st_cnt - 1;
      if (st_cnt == 1) begin
        div_busy <= 1'b0;
        div_quo <= st_q;
        div_rem <= st_r;
      end
    end
  end

  // Reference model: architectural result plus cycle-accurate timing expectations.
  function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a;
    end else if (!op[1] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = 32'd0;
    end else if (op[1]) begin
      q = a / b; r = a % b;
    end else begin
      q = $signed(a) / $signed(b); r = $signed(a) % $signed(b);
    end
    return op[0] ? r : q;
  endfunction

  function automatic logic is_fast(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef WIREDLEG_DIV_FASTPATH_EN
    return (b == 32'd0) || (!op[1] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
`else
    return 1'b0 & op[0] & a[0] & b[0];
`endif
  endfunction

  int               cyc = 0;
  logic             m_idle = 1'b1;
  logic             m_pend = 1'b0;
  logic             m_fast = 1'b0;
  int               m_acc = 0;
  int               m_due = 0;
  logic [31:0]      m_data = '0;
  logic [TAG_W-1:0] m_tag = '0;
  logic [31:0]      m_a = '0;
  logic [31:0]      m_b = '0;
  logic             m_sign = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst || flush) begin
      m_idle <= 1'b1;
      m_pend <= 1'b0;
    end else if (m_idle && req_valid) begin
      m_idle <= 1'b0;
      m_pend <= 1'b1;
      m_acc  <= cyc + 1;
      m_fast <= is_fast(req_op, req_a, req_b);
      m_due  <= cyc + 1 + (is_fast(req_op, req_a, req_b) ? 0 : 34);
      m_data <= ref_res(req_op, req_a, req_b);
      m_tag  <= req_tag;
      m_a    <= req_a;
      m_b    <= req_b;
      m_sign <= !req_op[1];
    end else if (m_pend && cyc >= m_due && resp_ready) begin
      m_idle <= 1'b1;
      m_pend <= 1'b0;
    end
  end

  logic chk_en = 1'b0;
  logic exp_rv;
  always @(negedge clk) begin
    if (chk_en) begin
      exp_rv = m_pend && (cyc >= m_due) && !flush;
      chk("req_ready", 32'(req_ready), 32'(m_idle && !flush));
      chk("busy", 32'(busy), 32'(!m_idle));
      chk("resp_valid", 32'(resp_valid), 32'(exp_rv));
      chk("div_start", 32'(div_start), 32'(m_pend && !m_fast && cyc == m_acc));
      if (exp_rv) begin
        chk("resp_data", resp_data, m_data);
        chk("resp_tag", 32'(resp_tag), 32'(m_tag));
      end
      if (m_pend && !m_fast && cyc >= m_acc && cyc < m_due) begin
        chk("div_a", div_a, m_a);
        chk("div_b", div_b, m_b);
        chk("div_sign", 32'(div_sign), 32'(m_sign));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [TAG_W-1:0] tag);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_tag = tag;
    step(1);
    req_valid = 1'b0;
  endtask

  task automatic wait_resp(input string nm, input logic [31:0] data, input logic [TAG_W-1:0] tag,
                           input int lat);
    int k = 0;
    logic found = 1'b0;
    while (k < 80 && !found) begin
      @(negedge clk);
      if (resp_valid) found = 1'b1;
      else k++;
    end
    if (!found) begin
      chk({nm, "_timeout"}, 32'd0, 32'd1);
    end else begin
      chk({nm, "_lat"}, 32'(k), 32'(lat));
      chk({nm, "_data"}, resp_data, data);
      chk({nm, "_tag"}, 32'(resp_tag), 32'(tag));
    end
    step(1);
  endtask

  initial begin
    int k;
    step(2);
    chk_en = 1'b1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_div_start", 32'(div_start), 32'd0);
    chk("rst_resp_data", resp_data, 32'd0);
    chk("rst_resp_tag", 32'(resp_tag), 32'd0);
    rst = 1'b0;
    step(1);

    req_valid = 1'b1; flush = 1'b1; req_op = 2'd0; req_a = 32'd4; req_b = 32'd2;
    step(1);
    req_valid = 1'b0; flush = 1'b0;
    chk("flush_idle_no_accept", 32'(busy), 32'd0);

    issue(2'd0, 32'd100, 32'd7, 5'd5);
    wait_resp("divw_100_7", 32'h0000_000E, 5'd5, 34);
    issue(2'd1, 32'hFFFF_FFF9, 32'd2, 5'd3);
    wait_resp("modw_m7_2", 32'hFFFF_FFFF, 5'd3, 34);
    issue(2'd2, 32'hFFFF_FFFF, 32'd2, 5'd9);
    wait_resp("divwu_max_2", 32'h7FFF_FFFF, 5'd9, 34);
    issue(2'd0, 32'd1234, 32'd0, 5'd4);
    wait_resp("divw_b0", 32'hFFFF_FFFF, 5'd4, FP_LAT);
    issue(2'd3, 32'd5, 32'd0, 5'd6);
    wait_resp("modwu_b0", 32'd5, 5'd6, FP_LAT);
    issue(2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7);
    wait_resp("divw_ovf", 32'h8000_0000, 5'd7, FP_LAT);
    issue(2'd1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8);
    wait_resp("modw_ovf", 32'd0, 5'd8, FP_LAT);
    issue(2'd2, 32'd7, 32'd0, 5'd10);
    wait_resp("divwu_b0", 32'hFFFF_FFFF, 5'd10, FP_LAT);

    issue(2'd0, 32'd50, 32'd5, 5'd1);
    step(11);
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    chk("flush_to_idle", 32'(busy), 32'd0);
    issue(2'd0, 32'd9, 32'd3, 5'd2);
    wait_resp("post_flush", 32'd3, 5'd2, 34);

    resp_ready = 1'b0;
    issue(2'd3, 32'd100, 32'd7, 5'd11);
    k = 0;
    while (k < 80 && !resp_valid) begin
      @(negedge clk);
      k++;
    end
    chk("bp_valid_seen", 32'(resp_valid), 32'd1);
    chk("bp_data", resp_data, 32'd2);
    step(1);
    req_valid = 1'b1; req_op = 2'd0; req_a = 32'd81; req_b = 32'd9; req_tag = 5'd12;
    step(5);
    chk("bp_hold_valid", 32'(resp_valid), 32'd1);
    chk("bp_hold_data", resp_data, 32'd2);
    chk("bp_hold_ready", 32'(req_ready), 32'd0);
    resp_ready = 1'b1;
    step(1);
    chk("bp_single", 32'(resp_valid), 32'd0);
    step(1);
    req_valid = 1'b0;
    wait_resp("bp_next", 32'd9, 5'd12, 34);

    issue(2'd0, 32'd1000, 32'd10, 5'd13);
    step(15);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("rst_mid_ready", 32'(req_ready), 32'd1);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    step(40);
    chk("rst_mid_no_resp", 32'(resp_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/wiredleg_div_ctrl.md
WIREDLEG_DIV_CTRL -- requirements
Module: wiredleg_div_ctrl

Interface
REQ-001 Parameter TAG_W SHALL be: default 5, width of the destination tag carried with each request.
REQ-002 Port clk SHALL be: input, 1, sole clock; all state updates on its rising edge.
REQ-003 Port rst SHALL be: input, 1, synchronous, active-high reset.
REQ-004 Port flush SHALL be: input, 1, pipeline flush; kills any in-flight operation.
REQ-005 Port req_valid SHALL be: input, 1, request present.
REQ-006 Port req_ready SHALL be: output, 1, request accepted on the same cycle as req_valid.
REQ-007 Port req_op SHALL be: input, 2; encoding 00 div.w, 01 mod.w, 10 div.wu, 11 mod.wu.
REQ-008 Ports req_a and req_b SHALL be: input, 32 each; dividend and divisor.
REQ-009 Port req_tag SHALL be: input, TAG_W, opaque tag returned with the result.
REQ-010 Port resp_valid SHALL be: output, 1, result available.
REQ-011 Port resp_ready SHALL be: input, 1, consumer takes the result.
REQ-012 Ports resp_data and resp_tag SHALL be: output, 32 and TAG_W; result and its tag.
REQ-013 Port busy SHALL be: output, 1, high whenever the FSM is not IDLE.
REQ-014 Ports div_start, div_sign, div_a and div_b SHALL be: output, 1/1/32/32; they drive the fixed-latency divider.
REQ-015 Ports div_busy, div_quo and div_rem SHALL be: input, 1/32/32; they carry divider status, quotient and remainder.

Function
REQ-016 The FSM SHALL have the states IDLE, START, WAIT and DONE.
REQ-017 req_ready SHALL equal (state==IDLE && !flush), and acceptance occurs on req_valid && req_ready.
REQ-018 On acceptance the block SHALL register op, a, b and tag; div_sign = !op[1]; select_rem = op[0]; next state START.
REQ-019 div_start SHALL be 1 only in START (exactly one cycle), and the next state is WAIT.
REQ-020 div_a, div_b and div_sign SHALL be driven from the registered operands and held stable in START and WAIT.
REQ-021 WAIT SHALL leave on the first cycle with div_busy==0, latching resp_data = select_rem ? div_rem : div_quo, and going to DONE.
REQ-022 Normal latency SHALL be: resp_valid high exactly 34 cycles after the acceptance edge.
REQ-023 DONE SHALL hold resp_valid, resp_data and resp_tag stable until resp_ready, then go to IDLE; no new request is accepted in the same cycle.
REQ-024 resp_valid SHALL be masked to 0 while flush is high, so no response transfer completes in a flush cycle.
REQ-025 Flush SHALL have priority over all transitions: any state goes to IDLE on the next edge, and the result is discarded.
REQ-026 After a flush the divider may still be running; the next START SHALL restart it (the divider gives start priority), and the stale result is never returned.
REQ-027 Signed overflow (A=0x80000000, B=0xFFFFFFFF) without fastpath SHALL return whatever the divider produces; no special handling.

Reset
REQ-028 While rst is high, at the edge the block SHALL set state=IDLE, resp_valid=0, div_start=0 and busy=0; req_ready=1 after reset.
REQ-029 Reset mid-operation SHALL abandon the operation and produce no response.
REQ-030 resp_data and resp_tag SHALL have reset value 0.

Configuration
REQ-031 The macro WIREDLEG_DIV_FASTPATH_EN, when defined, SHALL make acceptance with B==0 or signed overflow go directly to DONE (resp_valid 1 cycle after acceptance) without pulsing div_start.
REQ-032 In the fastpath, B==0 SHALL return 0xFFFFFFFF for quotient ops and A for remainder ops, for all four ops.
REQ-033 In the fastpath, signed overflow SHALL return quotient 0x80000000 and remainder 0.
REQ-034 Without the macro, every request SHALL go through START/WAIT with 34-cycle latency, and the result for B==0 is whatever the divider returns.

Verification
REQ-035 Bench SHALL cover: div.w A=100 B=7 -> resp_data 0x0000000E, 34 cycles after accept, tag echoed.
REQ-036 Bench SHALL cover: mod.w A=0xFFFFFFF9 (-7) B=2 -> 0xFFFFFFFF; div.wu A=0xFFFFFFFF B=2 -> 0x7FFFFFFF.
REQ-037 Bench SHALL cover: with the macro, div.w B=0 -> 0xFFFFFFFF next cycle, no div_start; mod.wu A=5 B=0 -> 5; overflow div.w -> 0x80000000.
REQ-038 Bench SHALL cover: flush 10 cycles into WAIT, then div.w 9/3 -> only 0x00000003 returned, 34 cycles after its own accept.
REQ-039 Bench SHALL cover: resp_ready low for 5 cycles in DONE -> resp_valid and resp_data stable, req_ready 0; single transfer on release.
REQ-040 Bench SHALL cover: rst pulse during WAIT -> no resp_valid; IDLE with req_ready=1 the next cycle.
